// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_param
// Description : Parameterised serial pattern detector. It supports overlapping
//               or non-overlapping matching and a pattern that can be loaded
//               at runtime. Optional saturating match counter is enabled by
//               the SEQDET_COUNT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             overlap_en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             match,
    output logic             match_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic [3:0]       fill
);

    localparam logic [3:0] c_fill_max = 4'(PAT_W - 1);

    logic [PAT_W-1:0] r_pat;
    logic [PAT_W-2:0] r_hist;
    logic [3:0]       r_fill;
    logic             r_match_q;

    logic [PAT_W-1:0] w_window;
    logic             w_match;

    // The newest bit joins the history at the LSB, so the window compares
    // oldest-first against the pattern MSB.
    assign w_window = {r_hist, din};
    assign w_match  = ~rst & din_valid & ~pat_load &
                      (r_fill == c_fill_max) & (w_window == r_pat);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat     <= PATTERN;
            r_hist    <= '0;
            r_fill    <= '0;
            r_match_q <= 1'b0;
        end else begin
            r_match_q <= w_match;
            if (pat_load) begin
                r_pat  <= pat_in;
                r_fill <= '0;
            end else if (din_valid) begin
                r_hist <= w_window[PAT_W-2:0];
                if (w_match && !overlap_en) begin
                    r_fill <= '0;
                end else if (r_fill != c_fill_max) begin
                    r_fill <= r_fill + 4'd1;
                end
            end
        end
    end

    assign match   = w_match;
    assign match_q = r_match_q;
    assign fill    = r_fill;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Clear takes precedence over a coincident match; the count never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_match && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign match_cnt = r_cnt;
    assign cnt_sat   = &r_cnt;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign match_cnt        = '0;
    assign cnt_sat          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_param
// Description : Directed self-checking bench for seq_detect_param. It drives a
//               default instance and a CNT_W=2 instance from shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

`ifdef SEQDET_COUNT_EN
    localparam bit c_cnt_on = 1'b1;
`else
    localparam bit c_cnt_on = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       overlap_en = 1'b1;
    logic       pat_load = 1'b0;
    logic [2:0] pat_in = 3'b000;
    logic       cnt_clr = 1'b0;

    logic       match, match_q, cnt_sat;
    logic [7:0] match_cnt;
    logic [3:0] fill;
    logic       match2, match_q2, cnt_sat2;
    logic [1:0] match_cnt2;
    logic [3:0] fill2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .match(match), .match_q(match_q),
        .match_cnt(match_cnt), .cnt_sat(cnt_sat), .fill(fill)
    );

    seq_detect_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .match(match2), .match_q(match_q2),
        .match_cnt(match_cnt2), .cnt_sat(cnt_sat2), .fill(fill2)
    );

    // Inputs change just after a rising edge; combinational outputs are
    // observed at the following falling edge.
    task automatic apply(input logic v, input logic d, input logic ld,
                         input logic [2:0] pin, input logic clr);
        din_valid = v;
        din       = d;
        pat_load  = ld;
        pat_in    = pin;
        cnt_clr   = clr;
        @(negedge clk);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst;
        rst = 1'b1;
        apply(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        apply(1'b1, 1'b1, 1'b1, 3'b111, 1'b1);
        checks++;
        if (match !== 1'b0) begin
            failures++; $display("FAIL reset_match got=%b exp=0", match);
        end
        tick();
        rst = 1'b0;
        apply(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        checks++;
        if (fill !== 4'd0 || match_q !== 1'b0) begin
            failures++; $display("FAIL reset_state fill=%0d match_q=%b exp fill=0 match_q=0", fill, match_q);
        end
        checks++;
        if (match_cnt !== 8'd0 || cnt_sat !== 1'b0) begin
            failures++; $display("FAIL reset_cnt cnt=%0d sat=%b exp cnt=0 sat=0", match_cnt, cnt_sat);
        end
        tick();
    endtask

    task automatic run_stream(input string name, input logic ovl,
                              input logic [4:0] exp_m, input int exp_cnt,
                              input logic [19:0] exp_fill);
        logic [4:0] bits;
        bits = 5'b10101;
        overlap_en = ovl;
        for (int i = 4; i >= 0; i--) begin
            apply(1'b1, bits[i], 1'b0, 3'b000, 1'b0);
            checks++;
            if (match !== exp_m[i]) begin
                failures++; $display("FAIL %s_match bit%0d got=%b exp=%b", name, 5 - i, match, exp_m[i]);
            end
            tick();
            checks++;
            if (match_q !== exp_m[i] || fill !== exp_fill[i*4 +: 4]) begin
                failures++;
                $display("FAIL %s_after bit%0d match_q=%b fill=%0d exp match_q=%b fill=%0d",
                         name, 5 - i, match_q, fill, exp_m[i], exp_fill[i*4 +: 4]);
            end
        end
        apply(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        checks++;
        if (match_cnt !== (c_cnt_on ? 8'(exp_cnt) : 8'd0)) begin
            failures++; $display("FAIL %s_cnt got=%0d exp=%0d", name, match_cnt, c_cnt_on ? exp_cnt : 0);
        end
        tick();
    endtask

    task automatic test_overlap;
        do_rst();
        run_stream("overlap", 1'b1, 5'b00101, 2, {4'd1, 4'd2, 4'd2, 4'd2, 4'd2});
    endtask

    task automatic test_non_overlap;
        do_rst();
        run_stream("nonovl", 1'b0, 5'b00100, 1, {4'd1, 4'd2, 4'd0, 4'd1, 4'd2});
        overlap_en = 1'b1;
    endtask

    task automatic test_gap;
        do_rst();
        apply(1'b1, 1'b1, 1'b0, 3'b000, 1'b0); tick();
        apply(1'b1, 1'b0, 1'b0, 3'b000, 1'b0); tick();
        for (int g = 0; g < 3; g++) begin
            apply(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
            checks++;
            if (match !== 1'b0) begin
                failures++; $display("FAIL gap_match cycle%0d got=%b exp=0", g, match);
            end
            tick();
        end
        checks++;
        if (fill !== 4'd2) begin
            failures++; $display("FAIL gap_fill got=%0d exp=2", fill);
        end
        apply(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        checks++;
        if (match !== 1'b1) begin
            failures++; $display("FAIL gap_final got=%b exp=1", match);
        end
        tick();
    endtask

    task automatic test_pat_load;
        logic [2:0] s;
        s = 3'b110;
        do_rst();
        apply(1'b0, 1'b0, 1'b1, 3'b110, 1'b0); tick();
        for (int i = 2; i >= 0; i--) begin
            apply(1'b1, s[i], 1'b0, 3'b000, 1'b0);
            checks++;
            if (match !== (i == 0)) begin
                failures++; $display("FAIL load_match bit%0d got=%b exp=%b", 3 - i, match, i == 0);
            end
            tick();
        end
        // Window 1,1 then a 0 alongside a load would complete 110, but the load wins.
        apply(1'b1, 1'b1, 1'b0, 3'b000, 1'b0); tick();
        apply(1'b1, 1'b1, 1'b0, 3'b000, 1'b0); tick();
        apply(1'b1, 1'b0, 1'b1, 3'b110, 1'b0);
        checks++;
        if (match !== 1'b0) begin
            failures++; $display("FAIL load_coincident_match got=%b exp=0", match);
        end
        tick();
        checks++;
        if (fill !== 4'd0) begin
            failures++; $display("FAIL load_coincident_fill got=%0d exp=0", fill);
        end
    endtask

    task automatic test_saturate;
        do_rst();
        overlap_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            apply(1'b1, (i % 2) == 0, 1'b0, 3'b000, 1'b0);
            tick();
        end
        apply(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        checks++;
        if (match_cnt2 !== (c_cnt_on ? 2'd3 : 2'd0) || cnt_sat2 !== c_cnt_on) begin
            failures++; $display("FAIL sat_cnt2 cnt=%0d sat=%b exp cnt=%0d sat=%b",
                                 match_cnt2, cnt_sat2, c_cnt_on ? 3 : 0, c_cnt_on);
        end
        checks++;
        if (match_cnt !== (c_cnt_on ? 8'd5 : 8'd0) || cnt_sat !== 1'b0) begin
            failures++; $display("FAIL sat_cnt8 cnt=%0d sat=%b exp cnt=%0d sat=0",
                                 match_cnt, cnt_sat, c_cnt_on ? 5 : 0);
        end
        tick();
        apply(1'b1, 1'b0, 1'b0, 3'b000, 1'b0); tick();
        apply(1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
        checks++;
        if (match !== 1'b1) begin
            failures++; $display("FAIL clr_match got=%b exp=1", match);
        end
        tick();
        apply(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        checks++;
        if (match_cnt !== 8'd0 || match_cnt2 !== 2'd0 || cnt_sat2 !== 1'b0) begin
            failures++; $display("FAIL clr_cnt cnt=%0d cnt2=%0d sat2=%b exp 0 0 0", match_cnt, match_cnt2, cnt_sat2);
        end
        tick();
    endtask

    task automatic test_rst_mid;
        do_rst();
        apply(1'b1, 1'b1, 1'b0, 3'b000, 1'b0); tick();
        apply(1'b1, 1'b0, 1'b0, 3'b000, 1'b0); tick();
        rst = 1'b1;
        apply(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        checks++;
        if (match !== 1'b0) begin
            failures++; $display("FAIL rst_forces_match got=%b exp=0", match);
        end
        tick();
        rst = 1'b0;
        apply(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
        checks++;
        if (match !== 1'b0) begin
            failures++; $display("FAIL rst_mid_match got=%b exp=0", match);
        end
        tick();
        checks++;
        if (fill !== 4'd1 || match_cnt !== 8'd0) begin
            failures++; $display("FAIL rst_mid_state fill=%0d cnt=%0d exp fill=1 cnt=0", fill, match_cnt);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gap();
        test_pat_load();
        test_saturate();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, default 3, pattern length in bits; legal range 2..8.
REQ-002 Parameter PATTERN, default 3'b101 (PAT_W bits), reset-time pattern; the MSB is the oldest bit.
REQ-003 Parameter CNT_W, default 8, match-counter width; legal range 1..16.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 din  in  1  serial data bit.
REQ-007 din_valid  in  1  din is sampled only in cycles where this is 1.
REQ-008 overlap_en  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
REQ-009 pat_load  in  1  load strobe for a runtime pattern.
REQ-010 pat_in  in  PAT_W  pattern value captured when pat_load=1.
REQ-011 cnt_clr  in  1  clears the match counter.
REQ-012 match  out  1  Mealy match, combinational from state and current inputs.
REQ-013 match_q  out  1  match registered by one cycle.
REQ-014 match_cnt  out  CNT_W  saturating count of matches.
REQ-015 cnt_sat  out  1  high while match_cnt equals all-ones.
REQ-016 fill  out  4  number of valid history bits, 0..PAT_W-1 (debug).

Function
REQ-017 The block SHALL hold a pattern register pat[PAT_W-1:0], a history register hist of PAT_W-1 bits, and a fill counter.
REQ-018 match SHALL equal din_valid & ~pat_load & (fill == PAT_W-1) & ({hist, din} == pat).
REQ-019 When din_valid=1 and pat_load=0 with no match, hist SHALL shift in din at the LSB, and fill SHALL increment, saturating at PAT_W-1.
REQ-020 On a match with overlap_en=1, hist SHALL shift in din and fill SHALL stay at PAT_W-1, so a suffix of the match can start the next match.
REQ-021 On a match with overlap_en=0, fill SHALL go to 0 and hist contents become don't-care, so no bit of the match is reused.
REQ-022 A cycle with din_valid=0 SHALL leave hist and fill unchanged and SHALL hold match at 0; gaps do not break a sequence.
REQ-023 When pat_load=1, pat SHALL load pat_in at the clock edge and fill SHALL go to 0.
REQ-024 pat_load=1 together with din_valid=1: the load wins, the din bit is discarded, and match is 0.
REQ-025 match_q SHALL be match delayed by exactly one clk cycle.
REQ-026 match_cnt SHALL increment by 1 on each cycle where match=1 and SHALL stop at 2^CNT_W-1 (no wrap).
REQ-027 cnt_clr=1 SHALL set match_cnt to 0 at the next edge; a match in the same cycle is not counted (clear wins).
REQ-028 overlap_en MAY change on any cycle and SHALL take effect for the match decision in that same cycle.
REQ-029 The detection latency is zero: match asserts in the same cycle as the final pattern bit.

Reset
REQ-030 While rst=1 at a rising edge, the following SHALL be set: pat=PATTERN, hist=0, fill=0, match_q=0, match_cnt=0; cnt_sat is then 0.
REQ-031 While rst=1, match SHALL be forced to 0.
REQ-032 rst asserted mid-sequence SHALL discard the partial history; a new match needs PAT_W fresh valid bits.
REQ-033 rst SHALL take priority over pat_load, cnt_clr and din_valid.

Configuration
REQ-034 Macro SEQDET_COUNT_EN: when defined, match_cnt and cnt_sat SHALL behave per REQ-026/027.
REQ-035 When SEQDET_COUNT_EN is undefined, match_cnt and cnt_sat SHALL be tied to 0, no counter flops SHALL exist, and cnt_clr is ignored.
REQ-036 match and match_q behaviour SHALL be identical with and without the macro.

Verification
REQ-037 Defaults (PAT_W=3, PATTERN=101), overlap_en=1, valid bits 1,0,1,0,1 -> match=1 on the 3rd and 5th bits; match_q=1 one cycle later each time; match_cnt=2.
REQ-038 Same stream with overlap_en=0 -> match only on the 3rd bit; match_cnt=1.
REQ-039 Stream 1,0,(din_valid=0 for 3 cycles),1 -> match=1 on the final bit, and match is 0 during the gap.
REQ-040 pat_load with pat_in=3'b110, then stream 1,1,0 -> match on the 3rd bit; pat_load coincident with a valid bit -> that bit is ignored and fill=0.
REQ-041 CNT_W=2 with the counter compiled in, 5 overlapping matches -> match_cnt=3 and cnt_sat=1; cnt_clr with a coincident match -> match_cnt=0.
REQ-042 rst pulsed after bits 1,0, then bit 1 -> no match and fill=1; rebuilt without SEQDET_COUNT_EN -> match_cnt=0 throughout.
